// File: rtl/sumador_secuencial.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with a registered ripple carry,
// returning the LEN1-bit result with carry and signed-overflow flags over valid/ready.
module sumador_secuencial #(
    parameter int LEN1  = 32,
    parameter int LEN2  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            sub,
    input  logic [LEN1-1:0] In1,
    input  logic [LEN2-1:0] In2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LEN1-1:0] Out,
    output logic            carry,
    output logic            overflow
);

    localparam int N  = LEN1 / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [LEN1-1:0]   r_a;
    logic [LEN1-1:0]   r_b;
    logic              r_c;
    logic [CW-1:0]     r_cnt;
    logic [LEN1-1:0]   r_out;
    logic              r_carry;
    logic              r_ovf;

    logic [LEN1-1:0]   w_b_ext;
    logic [CHUNK-1:0]  w_a_slice;
    logic [CHUNK-1:0]  w_b_slice;
    logic [CHUNK:0]    w_sum;
    logic              w_last;

    always_comb begin
        w_b_ext            = '0;
        w_b_ext[LEN2-1:0]  = In2;
    end

    // One slice of the ripple: bit CHUNK of w_sum is the carry into the next slice.
    always_comb begin
        w_a_slice = r_a[r_cnt*CHUNK +: CHUNK];
        w_b_slice = r_b[r_cnt*CHUNK +: CHUNK];
        w_sum     = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{CHUNK{1'b0}}, r_c};
        w_last    = (r_cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= In1;
                        r_b     <= sub ? ~w_b_ext : w_b_ext;
                        r_c     <= sub;
                        r_cnt   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_out[r_cnt*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
                    r_c   <= w_sum[CHUNK];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_carry <= w_sum[CHUNK];
                        r_ovf   <= (r_a[LEN1-1] == r_b[LEN1-1]) &&
                                   (w_sum[CHUNK-1] != r_a[LEN1-1]);
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign Out       = r_out;
    assign carry     = r_carry;
    assign overflow  = r_ovf;

endmodule
